// File: rtl/keypad_emu_pkg.sv
// keypad_emu_pkg: shared types and constants for the 4x4 keypad matrix emulator.
// Contents: FSM state enum, matrix geometry, LFSR seed/tap mask, key index helper.
// No ports; imported by keypad_matrix_emulator and lfsr16.
package keypad_emu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int KEY_W  = 4;
  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: bits 0,2,3,5 feed back.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Key index = row*4 + col.
  function automatic logic [KEY_W-1:0] key_index(input logic [1:0] r, input logic [1:0] c);
    return {r, c};
  endfunction

endpackage

// File: rtl/keypad_matrix_emulator_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR used as the contact-bounce noise source.
// Ports: clk_in, rst_in (async, active-high, loads seed), en (advance one step), q (state).
// Shifts right; the feedback bit enters at q[15], q[0] is the noise output.
module lfsr16
  import keypad_emu_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en,
  output logic [15:0] q
);

  logic fb;

  assign fb = ^(q & LFSR_TAPS);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {fb, q[15:1]};
    end
  end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator: far end of a 4x4 passive keypad matrix with contact bounce.
// Ports: clk_in/rst_in; row (active-low drive in) -> col (active-low return, 1-cycle registered);
//        cmd_valid/cmd_ready/cmd_key/cmd_press command port; done pulse, busy, key_state (settled keys).
module keypad_matrix_emulator
  import keypad_emu_pkg::*;
#(
  parameter int BOUNCE_CYCLES = 2000,
  parameter int CNT_W = (BOUNCE_CYCLES > 0) ? $clog2(BOUNCE_CYCLES + 1) : 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [KEY_W-1:0] cmd_key,
  input  logic             cmd_press,
  output logic             done,
  output logic             busy,
  output logic [15:0]      key_state
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] key_q;
  logic             target_q;
  logic [15:0]      raw_contact;
  logic [3:0]       col_d;
  logic [15:0]      lfsr_q;
  logic             lfsr_bit;
  logic [15:1]      lfsr_unused;
  logic             accept;
  logic             redundant;
  logic             last_bounce;

  assign {lfsr_unused, lfsr_bit} = lfsr_q;

  assign accept      = cmd_valid & cmd_ready;
  assign redundant   = (cmd_press == key_state[cmd_key]);
  assign last_bounce = (cnt == CNT_W'(1));

  lfsr16 u_lfsr (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en     (state == BOUNCE),
    .q      (lfsr_q)
  );

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (redundant || (BOUNCE_CYCLES == 0)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = BOUNCE;
          end
        end
      end
      BOUNCE: begin
        if (last_bounce) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. cmd_ready is gated by reset so the scanner never sees a handshake during reset.
  always_comb begin
    cmd_ready = (state == IDLE) & ~rst_in;
    busy      = (state == BOUNCE);
    done      = (state == DONE);
  end

  // Ideal diode matrix: a column is pulled low by any closed contact on a driven row.
  always_comb begin
    col_d = 4'hF;
    for (int c = 0; c < N_COLS; c++) begin
      for (int r = 0; r < N_ROWS; r++) begin
        if (raw_contact[key_index(2'(r), 2'(c))] && !row[r]) begin
          col_d[c] = 1'b0;
        end
      end
    end
  end

  // Datapath: command latch, bounce counter, contact and settled key state, column register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      col         <= 4'hF;
      cnt         <= '0;
      key_q       <= '0;
      target_q    <= 1'b0;
      raw_contact <= '0;
      key_state   <= '0;
    end else begin
      col <= col_d;
      case (state)
        IDLE: begin
          if (accept) begin
            key_q    <= cmd_key;
            target_q <= cmd_press;
            if (!redundant) begin
              if (BOUNCE_CYCLES == 0) begin
                raw_contact[cmd_key] <= cmd_press;
                key_state[cmd_key]   <= cmd_press;
              end else begin
                cnt <= CNT_W'(BOUNCE_CYCLES);
              end
            end
          end
        end
        BOUNCE: begin
          // The final cycle writes the clean target; earlier cycles chatter from the LFSR.
          if (last_bounce) begin
            raw_contact[key_q] <= target_q;
            key_state[key_q]   <= target_q;
          end else begin
            raw_contact[key_q] <= lfsr_bit;
            cnt                <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
`timescale 1ns/1ps
module tb_keypad_matrix_emulator;

  localparam int BC = 8;

  typedef struct {
    logic [15:0] ks;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // Instance with no bounce.
  logic        rst_z = 1'b0;
  logic [3:0]  row_z = 4'hF;
  logic [3:0]  col_z;
  logic        cmd_valid_z = 1'b0;
  logic        cmd_ready_z;
  logic [3:0]  cmd_key_z = 4'h0;
  logic        cmd_press_z = 1'b0;
  logic        done_z, busy_z;
  logic [15:0] ks_z;

  // Instance with an 8-cycle bounce.
  logic        rst_b = 1'b0;
  logic [3:0]  row_b = 4'hF;
  logic [3:0]  col_b;
  logic        cmd_valid_b = 1'b0;
  logic        cmd_ready_b;
  logic [3:0]  cmd_key_b = 4'h0;
  logic        cmd_press_b = 1'b0;
  logic        done_b, busy_b;
  logic [15:0] ks_b;

  keypad_matrix_emulator #(.BOUNCE_CYCLES(0)) dut_z (
    .clk_in(clk), .rst_in(rst_z), .row(row_z), .col(col_z),
    .cmd_valid(cmd_valid_z), .cmd_ready(cmd_ready_z), .cmd_key(cmd_key_z),
    .cmd_press(cmd_press_z), .done(done_z), .busy(busy_z), .key_state(ks_z)
  );

  keypad_matrix_emulator #(.BOUNCE_CYCLES(BC)) dut_b (
    .clk_in(clk), .rst_in(rst_b), .row(row_b), .col(col_b),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_key(cmd_key_b),
    .cmd_press(cmd_press_b), .done(done_b), .busy(busy_b), .key_state(ks_b)
  );

  exp_t        q_z[$];
  exp_t        q_b[$];
  logic [15:0] mdl_z = 16'h0;
  logic [15:0] mdl_b = 16'h0;
  logic [15:0] mdl_lfsr = 16'hACE1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  // Scoreboard monitors: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (done_z === 1'b1) begin
      if (q_z.size() == 0) chk("z_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q_z.pop_front();
        chk("z_done_key_state", ks_z, e.ks);
        chk("z_done_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        chk("b_done_key_state", ks_b, e.ks);
        chk("b_done_cycle", cyc, e.due);
      end
    end
  end

  // Offer a command, wait for the handshake edge t, push the expected outcome.
  // Returns #1 after edge t with the command inputs scrambled.
  task automatic issue_z(input logic [3:0] k, input logic p, output int t);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    cmd_valid_z = 1'b1; cmd_key_z = k; cmd_press_z = p;
    while (cmd_ready_z !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      chk("z_ready_timeout", 32'd0, 32'd1);
      cmd_valid_z = 1'b0; t = -1;
      return;
    end
    t = cyc + 1;
    mdl_z[k] = p;
    e.ks = mdl_z; e.due = t;
    q_z.push_back(e);
    @(posedge clk); #1;
    cmd_valid_z = 1'b0; cmd_key_z = ~k; cmd_press_z = ~p;
  endtask

  task automatic issue_b(input logic [3:0] k, input logic p, output int t, output logic [15:0] lstart);
    int   n;
    exp_t e;
    logic red;
    n = 0;
    @(negedge clk);
    cmd_valid_b = 1'b1; cmd_key_b = k; cmd_press_b = p;
    while (cmd_ready_b !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    lstart = mdl_lfsr;
    if (n >= 50) begin
      chk("b_ready_timeout", 32'd0, 32'd1);
      cmd_valid_b = 1'b0; t = -1;
      return;
    end
    t = cyc + 1;
    red = (mdl_b[k] == p);
    mdl_b[k] = p;
    e.ks = mdl_b; e.due = red ? t : t + BC;
    q_b.push_back(e);
    if (!red) repeat (BC) mdl_lfsr = lfsr_next(mdl_lfsr);
    @(posedge clk); #1;
    cmd_valid_b = 1'b0; cmd_key_b = ~k; cmd_press_b = ~p;
  endtask

  // Key 10 bounce window with row 2 driven: col[2] shows the inverted chatter one cycle late.
  task automatic window_b(input int t, input logic oldv, input logic newv, input logic [15:0] l0);
    logic [15:0] l;
    logic        c2;
    l = l0;
    for (int k = t; k <= t + BC + 1; k++) begin
      @(negedge clk);
      chk("b_busy_window", busy_b, (k < t + BC) ? 32'd1 : 32'd0);
      if (k <= t + 1) c2 = ~oldv;
      else if (k <= t + BC) begin c2 = ~l[0]; l = lfsr_next(l); end
      else c2 = ~newv;
      chk("b_col_window", col_b, {1'b1, c2, 2'b11});
    end
  endtask

  task automatic drain(input bit which_b);
    int n;
    n = 0;
    while ((which_b ? q_b.size() : q_z.size()) != 0 && n < 40) begin @(negedge clk); n++; end
    chk(which_b ? "b_drain" : "z_drain", which_b ? q_b.size() : q_z.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Stimulus: no-bounce instance.
  int z_done_flag = 0;
  initial begin
    int t, t2;
    #2 rst_z = 1'b1;
    #2;
    chk("z_rst_col", col_z, 32'hF);
    chk("z_rst_ks", ks_z, 32'h0);
    chk("z_rst_busy", busy_z, 32'd0);
    chk("z_rst_done", done_z, 32'd0);
    chk("z_rst_ready", cmd_ready_z, 32'd0);
    @(negedge clk); rst_z = 1'b0; #1;
    chk("z_ready_after_rst", cmd_ready_z, 32'd1);

    issue_z(4'd5, 1'b1, t);
    @(negedge clk); row_z = 4'b1101;
    @(negedge clk);
    chk("z_col_row1", col_z, 32'hD);
    row_z = 4'b1110;
    @(negedge clk);
    chk("z_col_row0_empty", col_z, 32'hF);

    issue_z(4'd0, 1'b1, t);
    issue_z(4'd3, 1'b1, t);
    @(negedge clk); row_z = 4'b1110;
    @(negedge clk);
    chk("z_col_keys0_3", col_z, 32'h6);
    issue_z(4'd13, 1'b1, t);
    @(negedge clk); row_z = 4'b0000;
    @(negedge clk);
    chk("z_col_all_rows", col_z, 32'h4);

    // Redundant release: no busy, done the cycle after the handshake.
    issue_z(4'd7, 1'b0, t);
    @(negedge clk);
    chk("z_redundant_busy", busy_z, 32'd0);

    // Back-to-back commands: one per two cycles.
    issue_z(4'd1, 1'b1, t);
    issue_z(4'd1, 1'b0, t2);
    chk("z_throughput", t2, t + 2);
    drain(1'b0);
    z_done_flag = 1;
  end

  // Stimulus: bounce instance.
  int b_done_flag = 0;
  initial begin
    int          t, t2;
    logic [15:0] ls;
    #2 rst_b = 1'b1;
    #2;
    chk("b_rst_col", col_b, 32'hF);
    chk("b_rst_ready", cmd_ready_b, 32'd0);
    @(negedge clk); rst_b = 1'b0; row_b = 4'b1011; #1;
    chk("b_ready_after_rst", cmd_ready_b, 32'd1);

    issue_b(4'd10, 1'b1, t, ls);
    window_b(t, 1'b0, 1'b1, ls);
    drain(1'b1);

    // Redundant release must not touch the LFSR; the next window proves it.
    issue_b(4'd7, 1'b0, t, ls);
    @(negedge clk);
    chk("b_redundant_busy", busy_b, 32'd0);
    drain(1'b1);
    issue_b(4'd10, 1'b0, t, ls);
    window_b(t, 1'b1, 1'b0, ls);
    drain(1'b1);

    // Command offered during bounce waits for the first IDLE cycle after done.
    issue_b(4'd1, 1'b1, t, ls);
    issue_b(4'd2, 1'b1, t2, ls);
    chk("b_hold_accept_cycle", t2, t + BC + 2);
    drain(1'b1);

    // Reset mid-bounce with key 5 settled.
    issue_b(4'd5, 1'b1, t, ls);
    drain(1'b1);
    issue_b(4'd6, 1'b1, t, ls);
    repeat (3) @(negedge clk);
    #2 rst_b = 1'b1;
    q_b.delete();
    mdl_b = 16'h0;
    mdl_lfsr = 16'hACE1;
    #1;
    chk("b_midrst_col", col_b, 32'hF);
    chk("b_midrst_ks", ks_b, 32'h0);
    chk("b_midrst_busy", busy_b, 32'd0);
    chk("b_midrst_done", done_b, 32'd0);
    chk("b_midrst_ready", cmd_ready_b, 32'd0);
    @(negedge clk); rst_b = 1'b0; #1;
    chk("b_ready_after_midrst", cmd_ready_b, 32'd1);
    @(negedge clk);
    chk("b_ready_next_cycle", cmd_ready_b, 32'd1);

    // LFSR restarts from the seed after reset.
    issue_b(4'd10, 1'b1, t, ls);
    window_b(t, 1'b0, 1'b1, ls);
    drain(1'b1);
    b_done_flag = 1;
  end

  initial begin
    int n;
    n = 0;
    while (!(z_done_flag && b_done_flag) && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) chk("stimulus_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_emulator.md
# keypad_matrix_emulator

Behavioural/synthesizable emulator of a 4x4 passive matrix keypad: the far end of the row/col scan interface driven by the keypad scanner. A command port presses or releases individual keys. The block answers the scanner's active-low row drive with active-low col returns, including contact bounce on each key change. It is used on-board for self-test and in benches as the stimulus source for the scanner and display path.

## Interface
Parameters:
- BOUNCE_CYCLES, default 2000: clk_in cycles of contact bounce after each accepted key change. 0 disables bounce.
- CNT_W, default $clog2(BOUNCE_CYCLES+1) (minimum 1): width of the bounce counter.

Ports:
- clk_in, in, 1: single system clock.
- rst_in, in, 1: asynchronous, active-high reset.
- row, in, 4: scanner row drive, active low; row[r]=0 selects row r.
- col, out, 4: column return, active low; idle 4'hF.
- cmd_valid, in, 1: command offered.
- cmd_ready, out, 1: block can accept a command.
- cmd_key, in, 4: key index = row*4 + col.
- cmd_press, in, 1: 1 = press, 0 = release.
- done, out, 1: one-cycle pulse when a command's key has settled.
- busy, out, 1: high in BOUNCE.
- key_state, out, 16: settled state of each key, bit = key index, 1 = pressed.

## Operation
- Internal raw_contact[15:0] holds the instantaneous contact of every key. key_state holds the settled value.
- Column model: col_d[c] = ~|( raw_contact[r*4+c] & ~row[r] ) over r = 0..3. Ideal diode matrix, no ghosting. col is registered from col_d.
- FSM states:
  - IDLE: cmd_ready=1. When cmd_valid & cmd_ready, latch the key and the target value.
    - Target equals key_state[key] (redundant command): go to DONE.
    - BOUNCE_CYCLES=0: write raw_contact and key_state, go to DONE.
    - Otherwise: load counter = BOUNCE_CYCLES, go to BOUNCE.
  - BOUNCE: raw_contact[key] = lfsr[0] each cycle. Counter decrements. The LFSR advances only in this state. When counter reaches 1, write raw_contact[key] and key_state[key] = target, then go to DONE.
  - DONE: done=1 for one cycle, cmd_ready=0. Return to IDLE.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1.
- Keys other than the latched key never change during a command.
- cmd_key and cmd_press are sampled only at the handshake edge; later changes are ignored.
- Reset (asynchronous, any state, including mid-bounce):
  - state=IDLE, raw_contact=0, key_state=0, col=4'hF.
  - done=0, busy=0, counter=0, lfsr=seed.
  - cmd_ready=0 while rst_in=1, and 1 in the first cycle after release.

## Timing
- col latency: row and raw_contact sampled at edge n appear on col after edge n (1 cycle).
- Bounce command accepted at edge t:
  - busy=1 for exactly BOUNCE_CYCLES cycles.
  - key_state updates at edge t+BOUNCE_CYCLES.
  - done is high during cycle t+BOUNCE_CYCLES+1; cmd_ready returns 1 in the next cycle.
- Redundant or BOUNCE_CYCLES=0 command at edge t: done is high in the cycle after t, and cmd_ready returns in the cycle after that. Maximum throughput is one command per 2 cycles.
- Multiple rows low at once: col_d is the OR over the selected rows, per the formula above. This case is legal and not flagged.
- The counter never wraps: it is loaded only in IDLE and stops at 1.

## Structure
- Package keypad_emu_pkg:
  - state enum {IDLE, BOUNCE, DONE}.
  - KEY_W=4, N_ROWS=4, N_COLS=4.
  - LFSR_SEED=16'hACE1 and the tap mask.
  - key index function row*4+col.
- Sub-module lfsr16: ports clk_in, rst_in, en, q[15:0], with the seed loaded on reset. All other logic lives in the top module.

## Test plan
- Reset: assert rst_in mid-run with key 5 pressed. Required: col=4'hF, key_state=16'h0000, busy=0, done=0 immediately. After release, cmd_ready=1 in the first cycle.
- BOUNCE_CYCLES=0, press key 5: done is high in the cycle after the handshake, key_state=16'h0020. Then:
  - row=4'b1101 gives col=4'b1101 one cycle later.
  - row=4'b1110 gives col=4'hF.
- BOUNCE_CYCLES=8, press key 10 with row=4'b1011 held:
  - busy=1 for 8 cycles and col[2] follows lfsr[0] during that window.
  - key_state=16'h0400 after edge t+8; done is high in cycle t+9; col settles to 4'b1011.
- Keys 0 and 3 pressed, row=4'b1110: col=4'b0110. With row=4'b0000 and key 13 also pressed: col=4'b0100.
- Release of key 7 while it is unpressed: no busy, done one cycle after the handshake, key_state unchanged, LFSR state unchanged.
- Handshake hold: during BOUNCE, cmd_valid=1 with a new key. Required: cmd_ready=0 and the command is not consumed. It is accepted exactly at the first IDLE cycle after done.
